cam_capture_stream: RTL and testbench

Parametrised camera pixel-capture engine that replaces the fixed RGB565 capture path behind SCCB initialisation. Oversamples the free-running camera bus (PCLK/HREF/VSYNC/data) in the system clock domain, assembles multi-byte pixels, applies a runtime crop window and frame decimation, and buffers pixels in an internal FIFO. Pixels leave on a valid/ready stream carrying start-of-frame and end-of-line markers, toward the SDRAM writer.

---
 rtl/cam_capture_stream_if.sv | 27 ++
 rtl/cam_capture_stream.sv | 276 +++++++++++++++++++++++++++
 tb/tb_cam_capture_stream.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_capture_stream_if.sv
// Pixel stream toward the SDRAM writer: show-ahead valid/ready channel
// carrying start-of-frame and end-of-line markers alongside each pixel.
interface cam_capture_stream_if #(
    parameter int PIX_W = 16
) ();
    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_data;
    logic             out_sof;
    logic             out_eol;

    modport master (
        output out_valid,
        output out_data,
        output out_sof,
        output out_eol,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_sof,
        input  out_eol,
        output out_ready
    );
endinterface

// File: rtl/cam_capture_stream.sv
// cam_capture_stream: oversamples the free-running camera bus in the system
// clock domain, assembles multi-beat pixels, applies a per-frame crop window
// and frame decimation, and buffers kept pixels in a show-ahead FIFO.
module cam_capture_stream #(
    parameter int DB_WIDTH         = 8,
    parameter int BYTES_PER_PIX    = 2,
    parameter int CNT_WIDTH        = 11,
    parameter int DECIM_WIDTH      = 4,
    parameter int FIFO_DEPTH_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmos_pclk,
    input  logic                   cmos_href,
    input  logic                   cmos_vsync,
    input  logic [DB_WIDTH-1:0]    cmos_db,
    input  logic                   cfg_en,
    input  logic [CNT_WIDTH-1:0]   cfg_x_start,
    input  logic [CNT_WIDTH-1:0]   cfg_x_end,
    input  logic [CNT_WIDTH-1:0]   cfg_y_start,
    input  logic [CNT_WIDTH-1:0]   cfg_y_end,
    input  logic [DECIM_WIDTH-1:0] cfg_decim,
    input  logic                   ovf_clr,
    cam_capture_stream_if.master   strm,
    output logic                   overflow,
    output logic [15:0]            frame_count,
    output logic                   busy
);
    localparam int PIX_W  = DB_WIDTH * BYTES_PER_PIX;
    localparam int BEAT_W = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
    localparam int DEPTH  = 1 << FIFO_DEPTH_WIDTH;
    localparam logic [BEAT_W-1:0]         LAST_BEAT = BEAT_W'(BYTES_PER_PIX - 1);
    localparam logic [CNT_WIDTH-1:0]      CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [FIFO_DEPTH_WIDTH:0] FULL_CNT  = {1'b1, {FIFO_DEPTH_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_SKIP    = 2'd3
    } state_t;

    // synchronisers and edge history
    logic [2:0]          pclk_sync_r;
    logic [1:0]          href_sync_r;
    logic [1:0]          vs_sync_r;
    logic [DB_WIDTH-1:0] db_meta_r;
    logic [DB_WIDTH-1:0] db_sync_r;
    logic                href_prev_r;
    logic                vs_prev_r;

    // frame control and per-frame shadow configuration
    state_t                 state_r;
    state_t                 state_n;
    logic [CNT_WIDTH-1:0]   x_start_r;
    logic [CNT_WIDTH-1:0]   x_end_r;
    logic [CNT_WIDTH-1:0]   y_start_r;
    logic [CNT_WIDTH-1:0]   y_end_r;
    logic [DECIM_WIDTH-1:0] decim_cnt_r;

    // pixel assembly
    logic [CNT_WIDTH-1:0] x_r;
    logic [CNT_WIDTH-1:0] y_r;
    logic [BEAT_W-1:0]    beat_r;
    logic [PIX_W-1:0]     pix_r;
    logic                 sof_pend_r;

    // FIFO, entry = {sof, eol, pixel}
    logic [PIX_W+1:0]            mem_r [DEPTH];
    logic [FIFO_DEPTH_WIDTH-1:0] wr_ptr_r;
    logic [FIFO_DEPTH_WIDTH-1:0] rd_ptr_r;
    logic [FIFO_DEPTH_WIDTH:0]   count_r;

    // status
    logic        overflow_r;
    logic [15:0] frame_count_r;
    logic        busy_r;

    // decoded strobes
    logic             pclk_rise_s;
    logic             href_fall_s;
    logic             vs_fall_s;
    logic             vs_rise_s;
    logic             frame_start_s;
    logic             in_frame_s;
    logic             beat_en_s;
    logic             pix_done_s;
    logic             in_win_s;
    logic             keep_s;
    logic             full_s;
    logic             wr_s;
    logic             rd_s;
    logic             eol_s;
    logic [PIX_W-1:0] pix_s;
    logic [PIX_W+1:0] head_s;

    assign pclk_rise_s   = pclk_sync_r[1] & ~pclk_sync_r[2];
    assign href_fall_s   = href_prev_r & ~href_sync_r[1];
    assign vs_fall_s     = vs_prev_r & ~vs_sync_r[1];
    assign vs_rise_s     = ~vs_prev_r & vs_sync_r[1];
    assign frame_start_s = (state_r == ST_WAIT_VS) && cfg_en && vs_fall_s;
    assign in_frame_s    = (state_r == ST_ACTIVE) || (state_r == ST_SKIP);
    assign beat_en_s     = in_frame_s && pclk_rise_s && href_sync_r[1];
    assign pix_done_s    = beat_en_s && (beat_r == LAST_BEAT);
    assign in_win_s      = (x_r >= x_start_r) && (x_r <= x_end_r) &&
                           (y_r >= y_start_r) && (y_r <= y_end_r);
    assign keep_s        = (state_r == ST_ACTIVE) && pix_done_s && in_win_s;
    assign eol_s         = (x_r == x_end_r);
    // full is judged on the registered count, so a same-cycle read cannot rescue a write
    assign full_s        = (count_r == FULL_CNT);
    assign wr_s          = keep_s && !full_s;
    assign rd_s          = (count_r != FULL_CNT - FULL_CNT) && strm.out_ready;

    assign overflow    = overflow_r;
    assign frame_count = frame_count_r;
    assign busy        = busy_r;

    // Resample the asynchronous camera bus; pclk gets an extra stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pclk_sync_r <= 3'b000;
            href_sync_r <= 2'b00;
            vs_sync_r   <= 2'b00;
            db_meta_r   <= {DB_WIDTH{1'b0}};
            db_sync_r   <= {DB_WIDTH{1'b0}};
            href_prev_r <= 1'b0;
            vs_prev_r   <= 1'b0;
        end else begin
            pclk_sync_r <= {pclk_sync_r[1:0], cmos_pclk};
            href_sync_r <= {href_sync_r[0], cmos_href};
            vs_sync_r   <= {vs_sync_r[0], cmos_vsync};
            db_meta_r   <= cmos_db;
            db_sync_r   <= db_meta_r;
            href_prev_r <= href_sync_r[1];
            vs_prev_r   <= vs_sync_r[1];
        end
    end

    // Frame state sequencing: frames start on vsync fall, end on vsync rise
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cfg_en) state_n = ST_WAIT_VS;
                else        state_n = ST_IDLE;
            end
            ST_WAIT_VS: begin
                if (!cfg_en)        state_n = ST_IDLE;
                else if (vs_fall_s) state_n = (decim_cnt_r == {DECIM_WIDTH{1'b0}}) ? ST_ACTIVE : ST_SKIP;
                else                state_n = ST_WAIT_VS;
            end
            ST_ACTIVE, ST_SKIP: begin
                if (vs_rise_s) state_n = cfg_en ? ST_WAIT_VS : ST_IDLE;
                else           state_n = state_r;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State register with busy decoded from the next state so it tracks state exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            busy_r  <= (state_n != ST_IDLE);
        end
    end

    // Shadow config, decimation, column/row/beat counters and beat assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_start_r   <= {CNT_WIDTH{1'b0}};
            x_end_r     <= {CNT_WIDTH{1'b0}};
            y_start_r   <= {CNT_WIDTH{1'b0}};
            y_end_r     <= {CNT_WIDTH{1'b0}};
            decim_cnt_r <= {DECIM_WIDTH{1'b0}};
            x_r         <= {CNT_WIDTH{1'b0}};
            y_r         <= {CNT_WIDTH{1'b0}};
            beat_r      <= {BEAT_W{1'b0}};
            pix_r       <= {PIX_W{1'b0}};
            sof_pend_r  <= 1'b0;
        end else if (frame_start_s) begin
            x_start_r   <= cfg_x_start;
            x_end_r     <= cfg_x_end;
            y_start_r   <= cfg_y_start;
            y_end_r     <= cfg_y_end;
            decim_cnt_r <= (decim_cnt_r == {DECIM_WIDTH{1'b0}}) ? cfg_decim : decim_cnt_r - 1'b1;
            x_r         <= {CNT_WIDTH{1'b0}};
            y_r         <= {CNT_WIDTH{1'b0}};
            beat_r      <= {BEAT_W{1'b0}};
            sof_pend_r  <= 1'b1;
        end else if (state_r == ST_IDLE) begin
            // the first frame after enable is always kept
            decim_cnt_r <= {DECIM_WIDTH{1'b0}};
        end else if (in_frame_s) begin
            if (href_fall_s) begin
                // end of line: any partial pixel is abandoned
                x_r    <= {CNT_WIDTH{1'b0}};
                beat_r <= {BEAT_W{1'b0}};
                if (y_r != CNT_MAX) y_r <= y_r + 1'b1;
            end else if (beat_en_s) begin
                for (int b = 0; b < BYTES_PER_PIX; b++) begin
                    if (beat_r == BEAT_W'(BYTES_PER_PIX - 1 - b))
                        pix_r[b*DB_WIDTH +: DB_WIDTH] <= db_sync_r;
                end
                if (beat_r == LAST_BEAT) begin
                    beat_r <= {BEAT_W{1'b0}};
                    if (x_r != CNT_MAX) x_r <= x_r + 1'b1;
                end else begin
                    beat_r <= beat_r + 1'b1;
                end
            end
            // sof belongs to the first kept pixel even if that pixel is dropped
            if (keep_s) sof_pend_r <= 1'b0;
        end
    end

    // Completed pixel: earlier beats from the assembly register, last beat straight from the bus
    always_comb begin
        pix_s                 = pix_r;
        pix_s[DB_WIDTH-1:0]   = db_sync_r;
    end

    // FIFO storage, written only when a kept pixel finds room
    always_ff @(posedge clk) begin
        if (wr_s) mem_r[wr_ptr_r] <= {sof_pend_r, eol_s, pix_s};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {FIFO_DEPTH_WIDTH{1'b0}};
            rd_ptr_r <= {FIFO_DEPTH_WIDTH{1'b0}};
            count_r  <= {(FIFO_DEPTH_WIDTH + 1){1'b0}};
        end else begin
            if (wr_s) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (rd_s) rd_ptr_r <= rd_ptr_r + 1'b1;
            case ({wr_s, rd_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Show-ahead head of FIFO, forced to zero while empty
    always_comb begin
        head_s = mem_r[rd_ptr_r];
        if (count_r != {(FIFO_DEPTH_WIDTH + 1){1'b0}}) begin
            strm.out_valid = 1'b1;
            strm.out_data  = head_s[PIX_W-1:0];
            strm.out_eol   = head_s[PIX_W];
            strm.out_sof   = head_s[PIX_W+1];
        end else begin
            strm.out_valid = 1'b0;
            strm.out_data  = {PIX_W{1'b0}};
            strm.out_eol   = 1'b0;
            strm.out_sof   = 1'b0;
        end
    end

    // Sticky overflow (a new drop beats a clear) and completed kept-frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r    <= 1'b0;
            frame_count_r <= 16'd0;
        end else begin
            if (keep_s && full_s) overflow_r <= 1'b1;
            else if (ovf_clr)     overflow_r <= 1'b0;
            if ((state_r == ST_ACTIVE) && vs_rise_s) frame_count_r <= frame_count_r + 16'd1;
        end
    end

endmodule

// File: tb/tb_cam_capture_stream.sv
// Directed-sequence bench with randomized pixel data: a camera-bus driver
// builds frames beat by beat while a frame-level model predicts which
// pixels (with sof/eol markers) must come out of the stream.
module tb_cam_capture_stream;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmos_pclk, cmos_href, cmos_vsync;
    logic [7:0]  cmos_db;
    logic        cfg_en;
    logic [10:0] cfg_x_start, cfg_x_end, cfg_y_start, cfg_y_end;
    logic [3:0]  cfg_decim;
    logic        ovf_clr;
    logic        overflow;
    logic [15:0] frame_count;
    logic        busy;

    cam_capture_stream_if #(.PIX_W(16)) strm ();

    cam_capture_stream dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmos_pclk   (cmos_pclk),
        .cmos_href   (cmos_href),
        .cmos_vsync  (cmos_vsync),
        .cmos_db     (cmos_db),
        .cfg_en      (cfg_en),
        .cfg_x_start (cfg_x_start),
        .cfg_x_end   (cfg_x_end),
        .cfg_y_start (cfg_y_start),
        .cfg_y_end   (cfg_y_end),
        .cfg_decim   (cfg_decim),
        .ovf_clr     (ovf_clr),
        .strm        (strm),
        .overflow    (overflow),
        .frame_count (frame_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int          tests  = 0;
    int          failed = 0;
    int          line_beats [8];
    int          frame_k  = 0;
    int          m_frames = 0;
    int          fc0;
    logic [7:0]  pat;
    logic [17:0] got [$];
    logic [17:0] exp_q [$];

    // Record every accepted stream beat as {sof, eol, data}
    always @(negedge clk) begin
        if (rst_n && strm.out_valid && strm.out_ready)
            got.push_back({strm.out_sof, strm.out_eol, strm.out_data});
    end

    // Watchdog so the bench always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_valid"}, 32'(strm.out_valid), 32'd0);
        chk({tag, "_data"},  32'(strm.out_data),  32'd0);
        chk({tag, "_sof"},   32'(strm.out_sof),   32'd0);
        chk({tag, "_eol"},   32'(strm.out_eol),   32'd0);
        chk({tag, "_ovf"},   32'(overflow),       32'd0);
        chk({tag, "_fc"},    32'(frame_count),    32'd0);
        chk({tag, "_busy"},  32'(busy),           32'd0);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk(tag, 32'(got[i]), 32'(exp_q[i]));
        got.delete();
        exp_q.delete();
    endtask

    task automatic drive_beat(input logic [7:0] d);
        cmos_href = 1'b1;
        cmos_db   = d;
        cmos_pclk = 1'b0;
        tick(2);
        cmos_pclk = 1'b1;
        tick(2);
    endtask

    task automatic end_line();
        cmos_pclk = 1'b0;
        cmos_href = 1'b0;
        tick(6);
    endtask

    task automatic restart_en();
        cfg_en = 1'b0;
        tick(4);
        chk("busy_idle", 32'(busy), 32'd0);
        cfg_en = 1'b1;
        tick(2);
        frame_k = 0;
    endtask

    // One frame: lines of line_beats[] beats; the model keeps frame k when
    // k is a multiple of (decim+1), and keeps pixels inside the crop window.
    // cap limits how many kept pixels can be buffered while the consumer stalls.
    task automatic run_frame(input int nlines, input bit rnd, input int cap);
        bit         keep;
        bit         sof_pend;
        int         kept;
        int         x;
        logic [7:0] hi;
        logic [7:0] bv;
        keep     = (frame_k % (int'(cfg_decim) + 1)) == 0;
        frame_k++;
        sof_pend = 1'b1;
        kept     = 0;
        hi       = 8'h00;
        cmos_vsync = 1'b0;
        tick(6);
        for (int l = 0; l < nlines; l++) begin
            for (int b = 0; b < line_beats[l]; b++) begin
                bv  = rnd ? 8'($urandom) : pat;
                pat = pat + 8'h11;
                x   = b / 2;
                if (b % 2 == 0) begin
                    hi = bv;
                end else if (keep && x >= int'(cfg_x_start) && x <= int'(cfg_x_end) &&
                             l >= int'(cfg_y_start) && l <= int'(cfg_y_end)) begin
                    if (kept < cap) exp_q.push_back({sof_pend, x == int'(cfg_x_end), hi, bv});
                    kept++;
                    sof_pend = 1'b0;
                end
                drive_beat(bv);
            end
            end_line();
        end
        cmos_vsync = 1'b1;
        tick(8);
        if (keep) m_frames++;
    endtask

    task automatic set_win(input int xs, input int xe, input int ys, input int ye);
        cfg_x_start = 11'(xs);
        cfg_x_end   = 11'(xe);
        cfg_y_start = 11'(ys);
        cfg_y_end   = 11'(ye);
    endtask

    initial begin
        rst_n      = 1'b0;
        cmos_pclk  = 1'b0;
        cmos_href  = 1'b0;
        cmos_vsync = 1'b1;
        cmos_db    = 8'h00;
        cfg_en     = 1'b0;
        cfg_decim  = 4'd0;
        ovf_clr    = 1'b0;
        strm.out_ready = 1'b1;
        set_win(0, 3, 0, 1);
        tick(3);
        check_idle_outputs("reset");
        rst_n  = 1'b1;
        cfg_en = 1'b1;
        tick(4);

        // Full 4x2 window, incrementing beat pattern
        line_beats[0] = 8;
        line_beats[1] = 8;
        pat = 8'hA1;
        run_frame(2, 1'b0, 1000);
        chk("first_pix", got.size() > 0 ? 32'(got[0]) : 32'hFFFF_FFFF, 32'h2_A1B2);
        check_stream("full");
        chk("full_fc", 32'(frame_count), 32'd1);

        // Crop x 1..2, y 1..1 on a 4x3 frame
        set_win(1, 2, 1, 1);
        line_beats[2] = 8;
        run_frame(3, 1'b1, 1000);
        chk("crop_n", 32'(got.size()), 32'd2);
        check_stream("crop");
        chk("crop_fc", 32'(frame_count), 32'(m_frames));

        // Decimation: keep 1 in 3 over 7 frames
        set_win(0, 1, 0, 0);
        line_beats[0] = 4;
        cfg_decim = 4'd2;
        restart_en();
        fc0 = m_frames;
        for (int f = 0; f < 7; f++) run_frame(1, 1'b1, 1000);
        check_stream("decim");
        chk("decim_fc", 32'(frame_count), 32'(fc0 + 3));

        // Stalled consumer: 20 pixels into a 16-deep FIFO
        cfg_decim = 4'd0;
        restart_en();
        strm.out_ready = 1'b0;
        set_win(0, 19, 0, 0);
        line_beats[0] = 40;
        run_frame(1, 1'b1, 16);
        chk("ovf_valid", 32'(strm.out_valid), 32'd1);
        chk("ovf_set",   32'(overflow),       32'd1);
        chk("ovf_held",  32'(got.size()),     32'd0);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        tick(1);
        chk("ovf_clr", 32'(overflow), 32'd0);
        strm.out_ready = 1'b1;
        tick(24);
        check_stream("ovf");
        chk("ovf_fc", 32'(frame_count), 32'(m_frames));

        // Partial pixel discarded when href drops after one beat
        set_win(0, 1, 0, 3);
        line_beats[0] = 1;
        line_beats[1] = 4;
        line_beats[2] = 3;
        run_frame(3, 1'b1, 1000);
        check_stream("partial");

        // Reset mid-line with 5 pixels buffered
        strm.out_ready = 1'b0;
        set_win(0, 15, 0, 3);
        cmos_vsync = 1'b0;
        tick(6);
        for (int b = 0; b < 11; b++) drive_beat(8'($urandom));
        chk("pre_rst_valid", 32'(strm.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        tick(3);
        rst_n = 1'b1;
        strm.out_ready = 1'b1;
        for (int b = 0; b < 3; b++) drive_beat(8'($urandom));
        end_line();
        cmos_vsync = 1'b1;
        tick(10);
        chk("post_rst_quiet", 32'(got.size()), 32'd0);
        got.delete();
        exp_q.delete();
        m_frames = 0;
        frame_k  = 0;
        set_win(0, 3, 0, 1);
        line_beats[0] = 8;
        line_beats[1] = 8;
        run_frame(2, 1'b1, 1000);
        check_stream("fresh");
        chk("fresh_fc", 32'(frame_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
